key_filter_multi: RTL and testbench



---
 rtl/key_pkg.sv | 15 +
 rtl/key_filter_ch.sv | 126 ++++++++++++
 rtl/key_filter_multi.sv | 62 ++++++
 tb/tb_key_filter_multi.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared encoding and sizing helpers for the multi-key push-button conditioner.
// The one-hot state values also appear on waveforms and in checkers.
package key_pkg;

   localparam logic [3:0] ST_IDLE    = 4'b0001;
   localparam logic [3:0] ST_FILTER1 = 4'b0010;
   localparam logic [3:0] ST_DOWN    = 4'b0100;
   localparam logic [3:0] ST_FILTER2 = 4'b1000;

   // Bits needed to hold 0..max_count; never narrower than one bit.
   function automatic int cnt_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold/repeat timing.
// All timing advances only on the shared tick; flags are registered 1-clk pulses.
module key_filter_ch
   import key_pkg::*;
#(
   parameter int DEB_TICKS    = 20,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_EN    = 0,
   parameter int REPEAT_TICKS = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic key_raw,
   output logic press_flag,
   output logic release_flag,
   output logic long_flag,
   output logic repeat_flag,
   output logic key_state
);

   localparam int W_F = cnt_width(DEB_TICKS - 1);
   localparam int W_H = cnt_width(LONG_TICKS - DEB_TICKS);
   localparam int W_R = cnt_width(REPEAT_TICKS - 1);
   localparam logic [W_F-1:0] F_LAST = W_F'(DEB_TICKS - 1);
   localparam logic [W_H-1:0] H_LONG = W_H'(LONG_TICKS - DEB_TICKS);
   localparam logic [W_R-1:0] R_LAST = W_R'(REPEAT_TICKS - 1);
   localparam bit REP_ON = (REPEAT_EN != 0);

   logic           sync1;
   logic           s;
   logic [3:0]     state;
   logic [W_F-1:0] fcnt;
   logic [W_H-1:0] hcnt;
   logic [W_R-1:0] rcnt;

   // Idle-high reset so no false edge is seen when reset releases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         s     <= 1'b1;
      end else begin
         sync1 <= key_raw;
         s     <= sync1;
      end
   end

   // hcnt/rcnt are held (not cleared) in FILTER2 so a bounce during
   // release neither restarts the hold nor re-fires long_flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         fcnt         <= '0;
         hcnt         <= '0;
         rcnt         <= '0;
         press_flag   <= 1'b0;
         release_flag <= 1'b0;
         long_flag    <= 1'b0;
         repeat_flag  <= 1'b0;
         key_state    <= 1'b1;
      end else begin
         press_flag   <= 1'b0;
         release_flag <= 1'b0;
         long_flag    <= 1'b0;
         repeat_flag  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!s) begin
                  state <= ST_FILTER1;
                  fcnt  <= '0;
               end
            end
            ST_FILTER1: begin
               if (s) begin
                  state <= ST_IDLE;
               end else if (tick) begin
                  if (fcnt == F_LAST) begin
                     state      <= ST_DOWN;
                     press_flag <= 1'b1;
                     key_state  <= 1'b0;
                     fcnt       <= '0;
                     hcnt       <= '0;
                     rcnt       <= '0;
                  end else begin
                     fcnt <= fcnt + 1'b1;
                  end
               end
            end
            ST_DOWN: begin
               if (s) begin
                  state <= ST_FILTER2;
                  fcnt  <= '0;
               end else if (tick) begin
                  if (hcnt != H_LONG) begin
                     hcnt <= hcnt + 1'b1;
                     if (hcnt == H_LONG - 1'b1) long_flag <= 1'b1;
                  end else if (REP_ON) begin
                     if (rcnt == R_LAST) begin
                        rcnt        <= '0;
                        repeat_flag <= 1'b1;
                     end else begin
                        rcnt <= rcnt + 1'b1;
                     end
                  end
               end
            end
            ST_FILTER2: begin
               if (!s) begin
                  state <= ST_DOWN;
               end else if (tick) begin
                  if (fcnt == F_LAST) begin
                     state        <= ST_IDLE;
                     release_flag <= 1'b1;
                     key_state    <= 1'b1;
                     fcnt         <= '0;
                  end else begin
                     fcnt <= fcnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/key_filter_multi.sv
// N-channel push-button conditioner: shared tick prescaler feeding
// independent per-key debounce channels, plus a registered any_pressed.
module key_filter_multi
   import key_pkg::*;
#(
   parameter int N_KEYS       = 4,
   parameter int CLK_PER_TICK = 50_000,
   parameter int DEB_TICKS    = 20,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_EN    = 0,
   parameter int REPEAT_TICKS = 200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] press_flag,
   output logic [N_KEYS-1:0] release_flag,
   output logic [N_KEYS-1:0] long_flag,
   output logic [N_KEYS-1:0] repeat_flag,
   output logic [N_KEYS-1:0] key_state,
   output logic              any_pressed
);

   localparam int W_P = cnt_width(CLK_PER_TICK - 1);
   localparam logic [W_P-1:0] P_LAST = W_P'(CLK_PER_TICK - 1);

   logic [W_P-1:0] pre_cnt;
   logic           tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   pre_cnt <= '0;
      else if (pre_cnt == P_LAST) pre_cnt <= '0;
      else                       pre_cnt <= pre_cnt + 1'b1;
   end

   assign tick = (pre_cnt == P_LAST);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_filter_ch #(
         .DEB_TICKS   (DEB_TICKS),
         .LONG_TICKS  (LONG_TICKS),
         .REPEAT_EN   (REPEAT_EN),
         .REPEAT_TICKS(REPEAT_TICKS)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .tick        (tick),
         .key_raw     (key_in[i]),
         .press_flag  (press_flag[i]),
         .release_flag(release_flag[i]),
         .long_flag   (long_flag[i]),
         .repeat_flag (repeat_flag[i]),
         .key_state   (key_state[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) any_pressed <= 1'b0;
      else     any_pressed <= ~&key_state;
   end

endmodule

// File: tb/tb_key_filter_multi.sv
// Bench for key_filter_multi: two instances (auto-repeat off / on) share the
// key pins and are compared every clock against a tick-level behavioural model.
module tb_key_filter_multi;

   localparam int N   = 2;
   localparam int CPT = 4;
   localparam int D   = 3;
   localparam int L   = 10;
   localparam int R   = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] key_in;
   logic [N-1:0] press0, rel0, long0, rep0, ks0;
   logic [N-1:0] press1, rel1, long1, rep1, ks1;
   logic         any0, any1;

   always #5 clk = ~clk;

   key_filter_multi #(.N_KEYS(N), .CLK_PER_TICK(CPT), .DEB_TICKS(D), .LONG_TICKS(L),
                      .REPEAT_EN(0), .REPEAT_TICKS(R)) u_dut0 (
      .clk(clk), .rst(rst), .key_in(key_in), .press_flag(press0), .release_flag(rel0),
      .long_flag(long0), .repeat_flag(rep0), .key_state(ks0), .any_pressed(any0));

   key_filter_multi #(.N_KEYS(N), .CLK_PER_TICK(CPT), .DEB_TICKS(D), .LONG_TICKS(L),
                      .REPEAT_EN(1), .REPEAT_TICKS(R)) u_dut1 (
      .clk(clk), .rst(rst), .key_in(key_in), .press_flag(press1), .release_flag(rel1),
      .long_flag(long1), .repeat_flag(rep1), .key_state(ks1), .any_pressed(any1));

   int n_vec = 0;
   int n_err = 0;

   // Reference model: accepted level, a filtering flag with its tick count,
   // and total ticks held since the first stable low.
   int           edge_cnt;
   bit           h1 [N];
   bit           h2 [N];
   bit           m_pressed [2][N];
   bit           m_filt    [2][N];
   int           m_fcnt    [2][N];
   int           m_hold    [2][N];
   int           m_rep     [2][N];
   logic [N-1:0] e_press [2];
   logic [N-1:0] e_rel   [2];
   logic [N-1:0] e_long  [2];
   logic [N-1:0] e_rep   [2];
   logic [N-1:0] e_ks    [2];
   logic         e_any   [2];

   // Observed pulse tallies for directed windows.
   int  t_press [2][N];
   int  t_rel   [2][N];
   int  t_long  [2][N];
   int  t_rep   [2][N];
   int  both_press_cycles;
   int  rel_hi_only_cycles;
   int  g_edge = 0;
   int  last_evt_edge = -1;
   bit  gap_chk_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      edge_cnt = 0;
      for (int k = 0; k < N; k++) begin
         h1[k] = 1'b1;
         h2[k] = 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < N; k++) begin
            m_pressed[d][k] = 1'b0;
            m_filt[d][k]    = 1'b0;
            m_fcnt[d][k]    = 0;
            m_hold[d][k]    = 0;
            m_rep[d][k]     = 0;
         end
         e_press[d] = '0; e_rel[d] = '0; e_long[d] = '0; e_rep[d] = '0;
         e_ks[d] = '1; e_any[d] = 1'b0;
      end
   endtask

   task automatic clear_tally();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < N; k++) begin
            t_press[d][k] = 0; t_rel[d][k] = 0; t_long[d][k] = 0; t_rep[d][k] = 0;
         end
      both_press_cycles  = 0;
      rel_hi_only_cycles = 0;
   endtask

   task automatic model_edge();
      bit s [N];
      bit tick_now;
      edge_cnt++;
      tick_now = ((edge_cnt % CPT) == 0);
      for (int k = 0; k < N; k++) begin
         s[k]  = h2[k];
         h2[k] = h1[k];
         h1[k] = key_in[k];
      end
      for (int d = 0; d < 2; d++) begin
         e_any[d] = 1'b0;
         for (int k = 0; k < N; k++) if (m_pressed[d][k]) e_any[d] = 1'b1;
         e_press[d] = '0; e_rel[d] = '0; e_long[d] = '0; e_rep[d] = '0;
         for (int k = 0; k < N; k++) begin
            if (!m_pressed[d][k]) begin
               if (!m_filt[d][k]) begin
                  if (!s[k]) begin m_filt[d][k] = 1'b1; m_fcnt[d][k] = 0; end
               end else if (s[k]) begin
                  m_filt[d][k] = 1'b0;
               end else if (tick_now) begin
                  m_fcnt[d][k]++;
                  if (m_fcnt[d][k] == D) begin
                     m_pressed[d][k] = 1'b1; m_filt[d][k] = 1'b0;
                     e_press[d][k] = 1'b1; m_hold[d][k] = D; m_rep[d][k] = 0;
                  end
               end
            end else begin
               if (!m_filt[d][k]) begin
                  if (s[k]) begin
                     m_filt[d][k] = 1'b1; m_fcnt[d][k] = 0;
                  end else if (tick_now) begin
                     if (m_hold[d][k] < L) begin
                        m_hold[d][k]++;
                        if (m_hold[d][k] == L) e_long[d][k] = 1'b1;
                     end else if (d == 1) begin
                        m_rep[d][k]++;
                        if (m_rep[d][k] == R) begin e_rep[d][k] = 1'b1; m_rep[d][k] = 0; end
                     end
                  end
               end else if (!s[k]) begin
                  m_filt[d][k] = 1'b0;
               end else if (tick_now) begin
                  m_fcnt[d][k]++;
                  if (m_fcnt[d][k] == D) begin
                     m_pressed[d][k] = 1'b0; m_filt[d][k] = 1'b0; e_rel[d][k] = 1'b1;
                  end
               end
            end
            e_ks[d][k] = ~m_pressed[d][k];
         end
      end
   endtask

   task automatic check_all();
      chk("press0",   32'(press0), 32'(e_press[0]));
      chk("release0", 32'(rel0),   32'(e_rel[0]));
      chk("long0",    32'(long0),  32'(e_long[0]));
      chk("repeat0",  32'(rep0),   32'(e_rep[0]));
      chk("state0",   32'(ks0),    32'(e_ks[0]));
      chk("any0",     32'(any0),   32'(e_any[0]));
      chk("press1",   32'(press1), 32'(e_press[1]));
      chk("release1", 32'(rel1),   32'(e_rel[1]));
      chk("long1",    32'(long1),  32'(e_long[1]));
      chk("repeat1",  32'(rep1),   32'(e_rep[1]));
      chk("state1",   32'(ks1),    32'(e_ks[1]));
      chk("any1",     32'(any1),   32'(e_any[1]));
   endtask

   // Called at a falling edge: drive pins, advance one clock, compare, tally.
   task automatic step(input logic [N-1:0] k);
      key_in = k;
      @(posedge clk);
      g_edge++;
      if (!rst) model_edge();
      #1;
      check_all();
      for (int i = 0; i < N; i++) begin
         t_press[0][i] += int'(press0[i]); t_press[1][i] += int'(press1[i]);
         t_rel[0][i]   += int'(rel0[i]);   t_rel[1][i]   += int'(rel1[i]);
         t_long[0][i]  += int'(long0[i]);  t_long[1][i]  += int'(long1[i]);
         t_rep[0][i]   += int'(rep0[i]);   t_rep[1][i]   += int'(rep1[i]);
      end
      if (press0 == 2'b11) both_press_cycles++;
      if (rel0 == 2'b10) rel_hi_only_cycles++;
      if (gap_chk_en && rep1[0]) chk("repeat_gap", 32'(g_edge - last_evt_edge), 32'(CPT * R));
      if (long1[0] || rep1[0]) last_evt_edge = g_edge;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_press"}, 32'({press0, press1}), 32'(0));
      chk({tag, "_rel"},   32'({rel0, rel1}),     32'(0));
      chk({tag, "_long"},  32'({long0, long1, rep0, rep1}), 32'(0));
      chk({tag, "_state"}, 32'({ks0, ks1}),       32'(4'b1111));
      chk({tag, "_any"},   32'({any0, any1}),     32'(0));
   endtask

   initial begin
      int           run_left [N];
      logic [N-1:0] lvl;

      rst    = 1'b1;
      key_in = '1;
      model_reset();
      clear_tally();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Idle with keys released.
      for (int i = 0; i < 100; i++) step(2'b11);
      chk("idle_no_press", 32'(t_press[0][0] + t_press[0][1] + t_press[1][0] + t_press[1][1]), 32'(0));

      // key0 low with a 1-clk high glitch every 6 clocks: must never be accepted.
      clear_tally();
      for (int i = 0; i < 40; i++) step({1'b1, (i % 6 == 5) ? 1'b1 : 1'b0});
      chk("glitch_no_press", 32'(t_press[0][0] + t_press[1][0]), 32'(0));

      // Stable low: exactly one press within the debounce window.
      clear_tally();
      for (int i = 0; i < 16; i++) step(2'b10);
      chk("press_once", 32'(t_press[0][0]), 32'(1));
      chk("press_state", 32'(ks0[0]), 32'(0));

      // Continue holding: one long press; repeats only on the repeat-enabled unit.
      clear_tally();
      gap_chk_en = 1'b1;
      for (int i = 0; i < 90; i++) step(2'b10);
      gap_chk_en = 1'b0;
      chk("long_once0", 32'(t_long[0][0]), 32'(1));
      chk("no_repeat0", 32'(t_rep[0][0]), 32'(0));
      chk("long_once1", 32'(t_long[1][0]), 32'(1));
      chk("repeat_seen1", 32'(t_rep[1][0] >= 3), 32'(1));

      // Release: one release pulse on both units.
      clear_tally();
      for (int i = 0; i < 30; i++) step(2'b11);
      chk("release_once0", 32'(t_rel[0][0]), 32'(1));
      chk("release_once1", 32'(t_rel[1][0]), 32'(1));
      chk("released_state", 32'({ks0, ks1}), 32'(4'b1111));

      // Both keys pressed together, then key1 released alone.
      clear_tally();
      for (int i = 0; i < 20; i++) step(2'b00);
      chk("both_press_same_cycle", 32'(both_press_cycles), 32'(1));
      for (int i = 0; i < 20; i++) step(2'b10);
      chk("release_key1_only", 32'(rel_hi_only_cycles), 32'(1));

      // Reset while key0 is held down, key0 released during reset.
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_reset_outputs("midrst");
      for (int i = 0; i < 4; i++) step(2'b11);
      rst = 1'b0;
      clear_tally();
      for (int i = 0; i < 40; i++) step(2'b11);
      chk("no_release_after_rst", 32'(t_rel[0][0] + t_rel[1][0]), 32'(0));

      // Randomised bouncy key activity on both channels.
      lvl = 2'b11;
      for (int k = 0; k < N; k++) run_left[k] = $urandom_range(1, 30);
      for (int i = 0; i < 4000; i++) begin
         for (int k = 0; k < N; k++) begin
            if (run_left[k] == 0) begin
               lvl[k] = ~lvl[k];
               run_left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(4, 60);
            end
            run_left[k]--;
         end
         if (i == 2000) begin
            #3 rst = 1'b1;
            #1;
            model_reset();
            check_reset_outputs("randrst");
            step(lvl);
            step(lvl);
            rst = 1'b0;
         end
         step(lvl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
